cla_accumulator: RTL and testbench



---
 rtl/cla_pkg.sv | 16 +
 rtl/carry_lookahead_adder.sv | 42 ++++
 rtl/cla_accumulator.sv | 117 +++++++++++
 tb/tb_cla_accumulator.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the carry-lookahead accumulator.
package cla_pkg;

   // Block-level sequencing: collect pairs, flush the last pair, present the total.
   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } cla_acc_state_t;

   // Default accumulator width: one pair sum plus enough headroom for COUNT of them.
   function automatic int cla_acc_width(input int width, input int count);
      return width + 1 + $clog2(count);
   endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Combinational WIDTH-bit adder with fully expanded lookahead carries.
module carry_lookahead_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   output logic [WIDTH:0]   o_result
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;

   // Carry into bit i+1: any lower generate whose carry propagates all the way up.
   function automatic logic lookahead(input logic [WIDTH-1:0] g,
                                      input logic [WIDTH-1:0] p,
                                      input int               i);
      logic c;
      logic chain;
      c = 1'b0;
      for (int j = 0; j <= i; j++) begin
         chain = 1'b1;
         for (int k = j + 1; k <= i; k++) begin
            chain = chain & p[k];
         end
         c = c | (g[j] & chain);
      end
      return c;
   endfunction

   assign gen   = i_add1 & i_add2;
   assign prop  = i_add1 ^ i_add2;
   assign carry[0] = 1'b0;

   // Each carry is formed directly from generate/propagate terms, not rippled.
   for (genvar i = 0; i < WIDTH; i++) begin : g_carry
      assign carry[i+1] = lookahead(gen, prop, i);
   end

   assign o_result = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/cla_accumulator.sv
// Accumulates COUNT operand-pair sums per block and hands the total off on a valid/ready port.
module cla_accumulator
   import cla_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int COUNT     = 4,
   parameter int ACC_WIDTH = cla_acc_width(WIDTH, COUNT)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WIDTH-1:0]     i_add1,
   input  logic [WIDTH-1:0]     i_add2,
   output logic                 o_sum_valid,
   input  logic                 i_sum_ready,
   output logic [ACC_WIDTH-1:0] o_sum,
   output logic                 o_overflow
);

   localparam int CNT_W = $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

   cla_acc_state_t state;
   cla_acc_state_t next_state;

   logic [CNT_W-1:0]     in_cnt;
   logic                 op_vld;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic [WIDTH:0]       pair_sum;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH:0]   acc_next;
   logic                 accept;
   logic                 last_accept;
   logic                 take_sum;

   assign o_ready     = (state == ACCUM);
   assign o_sum_valid = (state == DONE);
   assign o_sum       = acc;

   assign accept      = i_valid && o_ready;
   assign last_accept = accept && (in_cnt == LAST_CNT);
   assign take_sum    = (state == DONE) && i_sum_ready;
   assign acc_next    = {1'b0, acc} + {{(ACC_WIDTH - WIDTH){1'b0}}, pair_sum};

   carry_lookahead_adder #(
      .WIDTH(WIDTH)
   ) u_adder (
      .i_add1  (op_a),
      .i_add2  (op_b),
      .o_result(pair_sum)
   );

   // State register for the block sequencer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ACCUM;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: the DRAIN beat lets the final captured pair reach the accumulator.
   always_comb begin
      next_state = state;
      case (state)
         ACCUM:   if (last_accept) next_state = DRAIN;
         DRAIN:   next_state = DONE;
         DONE:    if (i_sum_ready) next_state = ACCUM;
         default: next_state = ACCUM;
      endcase
   end

   // Operand capture: one register stage ahead of the adder, valid only on accepted beats.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_vld <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
      end else begin
         op_vld <= accept;
         if (accept) begin
            op_a <= i_add1;
            op_b <= i_add2;
         end
      end
   end

   // Pair counter: counts accepts in the block, restarts when the total is taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         in_cnt <= '0;
      end else if (take_sum) begin
         in_cnt <= '0;
      end else if (accept) begin
         in_cnt <= in_cnt + 1'b1;
      end
   end

   // Accumulator with sticky overflow; both clear once the consumer takes the total.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc        <= '0;
         o_overflow <= 1'b0;
      end else if (take_sum) begin
         acc        <= '0;
         o_overflow <= 1'b0;
      end else if (op_vld) begin
         acc <= acc_next[ACC_WIDTH-1:0];
         if (acc_next[ACC_WIDTH]) begin
            o_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cla_accumulator.sv
// Self-checking bench for cla_accumulator: default, narrow-accumulator and COUNT=1 instances.
module tb_cla_accumulator;

   logic        clk;
   logic        rst_n;

   // Shared stimulus for the default and the 10-bit accumulator instances
   logic        valid;
   logic [7:0]  add1;
   logic [7:0]  add2;
   logic        sum_ready;
   logic        ready;
   logic        sum_valid;
   logic [10:0] sum;
   logic        ovf;
   logic        n_ready;
   logic        n_sum_valid;
   logic [9:0]  n_sum;
   logic        n_ovf;

   // COUNT=1 instance
   logic        c1_valid;
   logic [7:0]  c1_add1;
   logic [7:0]  c1_add2;
   logic        c1_sum_ready;
   logic        c1_ready;
   logic        c1_sum_valid;
   logic [8:0]  c1_sum;
   logic        c1_ovf;

   int checks;
   int errors;
   int cyc;

   logic [7:0] pa [4];
   logic [7:0] pb [4];

   cla_accumulator dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
      .i_add1(add1), .i_add2(add2), .o_sum_valid(sum_valid),
      .i_sum_ready(sum_ready), .o_sum(sum), .o_overflow(ovf)
   );

   cla_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) dut_narrow (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(n_ready),
      .i_add1(add1), .i_add2(add2), .o_sum_valid(n_sum_valid),
      .i_sum_ready(sum_ready), .o_sum(n_sum), .o_overflow(n_ovf)
   );

   cla_accumulator #(.WIDTH(8), .COUNT(1)) dut_c1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(c1_valid), .o_ready(c1_ready),
      .i_add1(c1_add1), .i_add2(c1_add2), .o_sum_valid(c1_sum_valid),
      .i_sum_ready(c1_sum_ready), .o_sum(c1_sum), .o_overflow(c1_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: the block total is the plain integer sum of all pair sums.
   function automatic int block_total();
      int t;
      t = 0;
      for (int i = 0; i < 4; i++) t += int'(pa[i]) + int'(pb[i]);
      return t;
   endfunction

   function automatic void set_pairs(input int a0, b0, a1, b1, a2, b2, a3, b3);
      pa[0] = 8'(a0); pb[0] = 8'(b0);
      pa[1] = 8'(a1); pb[1] = 8'(b1);
      pa[2] = 8'(a2); pb[2] = 8'(b2);
      pa[3] = 8'(a3); pb[3] = 8'(b3);
   endfunction

   // Offer the four pairs in pa/pb; returns right after the edge of the last accept.
   task automatic drive_block(input bit gapped);
      int idx;
      int guard;
      bit phase;
      bit took;
      idx = 0;
      guard = 0;
      phase = 1'b0;
      while (idx < 4 && guard < 64) begin
         valid = gapped ? phase : 1'b1;
         add1  = valid ? pa[idx] : 8'($urandom);
         add2  = valid ? pb[idx] : 8'($urandom);
         checks++;
         if (ready !== 1'b1 || n_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_in_accum got %b/%b want 1", ready, n_ready);
         end
         took = valid && ready;
         @(posedge clk); #1;
         if (took) idx++;
         phase = ~phase;
         guard++;
      end
      valid = 1'b0;
      checks++;
      if (guard >= 64) begin
         errors++;
         $display("[TB] FAIL accept_timeout accepted %0d want 4", idx);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (sum !== 11'd0 || ovf !== 1'b0 || sum_valid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_outputs sum=%0d ovf=%b vld=%b rdy=%b want 0/0/0/1",
                  sum, ovf, sum_valid, ready);
      end
      checks++;
      if (c1_sum !== 9'd0 || c1_sum_valid !== 1'b0 || n_sum !== 10'd0 || n_ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_other c1_sum=%0d c1_vld=%b n_sum=%0d n_ovf=%b want 0",
                  c1_sum, c1_sum_valid, n_sum, n_ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || sum_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset rdy=%b vld=%b want 1/0", ready, sum_valid);
      end
   endtask

   task automatic test_basic();
      int exp;
      set_pairs(1, 2, 3, 4, 250, 10, 255, 255);
      exp = block_total();
      drive_block(1'b0);
      checks++;
      if (ready !== 1'b0 || sum_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_drain rdy=%b vld=%b want 0/0", ready, sum_valid);
      end
      valid = 1'b1; add1 = 8'hAA; add2 = 8'h55;
      @(posedge clk); #1;
      checks++;
      if (sum_valid !== 1'b1 || sum !== 11'(exp) || ovf !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_total vld=%b sum=%0d ovf=%b rdy=%b want 1/%0d/0/0",
                  sum_valid, sum, ovf, ready, exp);
      end
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
      valid = 1'b0;
      checks++;
      if (sum_valid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_release vld=%b rdy=%b want 0/1", sum_valid, ready);
      end
   endtask

   task automatic test_back_pressure();
      int exp;
      set_pairs(1, 2, 3, 4, 250, 10, 255, 255);
      exp = block_total();
      drive_block(1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (sum_valid !== 1'b1 || sum !== 11'(exp) || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cycle %0d vld=%b sum=%0d rdy=%b want 1/%0d/0",
                     i, sum_valid, sum, ready, exp);
         end
         valid = 1'b1; add1 = 8'($urandom); add2 = 8'($urandom);
         @(posedge clk); #1;
      end
      valid = 1'b0;
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
      checks++;
      if (sum_valid !== 1'b0 || ready !== 1'b1 || sum !== 11'd0) begin
         errors++;
         $display("[TB] FAIL bp_release vld=%b rdy=%b sum=%0d want 0/1/0", sum_valid, ready, sum);
      end
   endtask

   task automatic test_gapped();
      int exp;
      set_pairs(1, 2, 3, 4, 250, 10, 255, 255);
      exp = block_total();
      drive_block(1'b1);
      @(posedge clk); #1;
      checks++;
      if (sum_valid !== 1'b1 || sum !== 11'(exp) || ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gapped_total vld=%b sum=%0d ovf=%b want 1/%0d/0",
                  sum_valid, sum, ovf, exp);
      end
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
   endtask

   task automatic test_overflow();
      int exp;
      set_pairs(255, 255, 255, 255, 255, 255, 255, 255);
      exp = block_total();
      drive_block(1'b0);
      @(posedge clk); #1;
      checks++;
      if (n_sum_valid !== 1'b1 || n_sum !== 10'(exp % 1024) || n_ovf !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_narrow vld=%b sum=%0d ovf=%b want 1/%0d/1",
                  n_sum_valid, n_sum, n_ovf, exp % 1024);
      end
      checks++;
      if (sum !== 11'(exp) || ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_wide sum=%0d ovf=%b want %0d/0", sum, ovf, exp);
      end
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
      set_pairs(0, 0, 0, 0, 0, 0, 0, 0);
      drive_block(1'b0);
      @(posedge clk); #1;
      checks++;
      if (n_sum_valid !== 1'b1 || n_sum !== 10'd0 || n_ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_cleared vld=%b sum=%0d ovf=%b want 1/0/0",
                  n_sum_valid, n_sum, n_ovf);
      end
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
   endtask

   task automatic test_random();
      int exp;
      int stall;
      for (int blk = 0; blk < 8; blk++) begin
         for (int i = 0; i < 4; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
         end
         if (blk[0]) begin
            pa[0] = 8'hFF; pb[0] = 8'hFF; pa[1] = 8'hF0; pb[1] = 8'hFE;
         end
         exp = block_total();
         stall = $urandom_range(0, 3);
         drive_block(1'($urandom));
         @(posedge clk); #1;
         for (int s = 0; s <= stall; s++) begin
            checks++;
            if (sum_valid !== 1'b1 || sum !== 11'(exp % 2048) || ovf !== (exp > 2047)) begin
               errors++;
               $display("[TB] FAIL rand_wide blk %0d vld=%b sum=%0d ovf=%b want 1/%0d/%b",
                        blk, sum_valid, sum, ovf, exp % 2048, exp > 2047);
            end
            checks++;
            if (n_sum_valid !== 1'b1 || n_sum !== 10'(exp % 1024) || n_ovf !== (exp > 1023)) begin
               errors++;
               $display("[TB] FAIL rand_narrow blk %0d vld=%b sum=%0d ovf=%b want 1/%0d/%b",
                        blk, n_sum_valid, n_sum, n_ovf, exp % 1024, exp > 1023);
            end
            if (s < stall) begin
               @(posedge clk); #1;
            end
         end
         sum_ready = 1'b1;
         @(posedge clk); #1;
         sum_ready = 1'b0;
      end
   endtask

   task automatic test_count1();
      int q [$];
      int last_vld;
      int seen;
      int got;
      bit took;
      c1_valid = 1'b1; c1_add1 = 8'd200; c1_add2 = 8'd100;
      checks++;
      if (c1_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL c1_ready got %b want 1", c1_ready);
      end
      @(posedge clk); #1;
      c1_valid = 1'b0;
      checks++;
      if (c1_sum_valid !== 1'b0 || c1_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL c1_drain vld=%b rdy=%b want 0/0", c1_sum_valid, c1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (c1_sum_valid !== 1'b1 || c1_sum !== 9'd300) begin
         errors++;
         $display("[TB] FAIL c1_total vld=%b sum=%0d want 1/300", c1_sum_valid, c1_sum);
      end
      c1_sum_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (c1_sum_valid !== 1'b0 || c1_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL c1_release vld=%b rdy=%b want 0/1", c1_sum_valid, c1_ready);
      end
      // Back-to-back blocks: one total every three cycles
      last_vld = -1;
      seen = 0;
      c1_valid = 1'b1;
      c1_add1 = 8'($urandom); c1_add2 = 8'($urandom);
      for (int i = 0; i < 16; i++) begin
         took = c1_ready;
         if (took) q.push_back(int'(c1_add1) + int'(c1_add2));
         @(posedge clk); #1;
         if (took) begin
            c1_add1 = 8'($urandom); c1_add2 = 8'($urandom);
         end
         if (c1_sum_valid === 1'b1) begin
            got = (q.size() > 0) ? q.pop_front() : -1;
            checks++;
            if (c1_sum !== 9'(got) || got < 0) begin
               errors++;
               $display("[TB] FAIL c1_b2b_sum got %0d want %0d", c1_sum, got);
            end
            if (last_vld >= 0) begin
               checks++;
               if (cyc - last_vld != 3) begin
                  errors++;
                  $display("[TB] FAIL c1_period got %0d want 3", cyc - last_vld);
               end
            end
            last_vld = cyc;
            seen++;
         end
      end
      c1_valid = 1'b0;
      checks++;
      if (seen < 4) begin
         errors++;
         $display("[TB] FAIL c1_b2b_count got %0d want >=4", seen);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      c1_sum_ready = 1'b0;
   endtask

   task automatic test_reset_mid_block();
      int exp;
      valid = 1'b1; add1 = 8'd5; add2 = 8'd7;
      @(posedge clk); #1;
      add1 = 8'd9; add2 = 8'd9;
      @(posedge clk); #1;
      valid = 1'b0;
      checks++;
      if (sum !== 11'd12) begin
         errors++;
         $display("[TB] FAIL mid_partial sum=%0d want 12", sum);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (sum !== 11'd0 || ovf !== 1'b0 || sum_valid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset sum=%0d ovf=%b vld=%b rdy=%b want 0/0/0/1",
                  sum, ovf, sum_valid, ready);
      end
      #2;
      rst_n = 1'b1;
      set_pairs(1, 1, 1, 1, 1, 1, 1, 1);
      exp = block_total();
      drive_block(1'b0);
      @(posedge clk); #1;
      checks++;
      if (sum_valid !== 1'b1 || sum !== 11'(exp)) begin
         errors++;
         $display("[TB] FAIL mid_fresh vld=%b sum=%0d want 1/%0d", sum_valid, sum, exp);
      end
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      rst_n = 1'b0;
      valid = 1'b0; add1 = '0; add2 = '0; sum_ready = 1'b0;
      c1_valid = 1'b0; c1_add1 = '0; c1_add2 = '0; c1_sum_ready = 1'b0;
      #12;
      test_reset();
      test_basic();
      test_back_pressure();
      test_gapped();
      test_overflow();
      test_random();
      test_count1();
      test_reset_mid_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
